pipe_control_unit: RTL and testbench

PIPE_CONTROL_UNIT -- requirements
Module: pipe_control_unit

---
 rtl/pipe_control_unit_pkg.sv | 66 ++++++
 rtl/pipe_control_unit_decoder.sv | 106 ++++++++++
 rtl/pipe_control_unit.sv | 184 ++++++++++++++++++
 tb/tb_pipe_control_unit.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_control_unit_pkg.sv
// Shared decode constants and control-bundle types for the pipeline control unit.
// Opcode/funct fields follow the RV32I base encoding; bundles are split per stage.
package pipe_control_unit_pkg;

    localparam int OPC_LSB     = 0;
    localparam int OPC_MSB     = 6;
    localparam int F3_LSB      = 12;
    localparam int F3_MSB      = 14;
    localparam int F7_LSB      = 25;
    localparam int F7_MSB      = 31;
    localparam int SYS_IMM_BIT = 20;
    localparam int DRAIN_CNT_W = 3;

    localparam logic [6:0] OPC_ARITH_R = 7'b0110011;
    localparam logic [6:0] OPC_ARITH_I = 7'b0010011;
    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;
    localparam logic [6:0] OPC_FENCE   = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_BRANCH = 2'b01;
    localparam logic [1:0] ALU_FUNCT  = 2'b10;
    localparam logic [1:0] ALU_LUI    = 2'b11;

    typedef struct packed {
        logic [1:0] alu_op;
        logic       alu_src;
        logic       branch;
        logic       jump;
        logic       jalr;
        logic       auipc_sel;
        logic       rf_sel;
    } ex_ctrl_t;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic [1:0] save_method;
    } mem_ctrl_t;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
    } wb_ctrl_t;

    typedef struct packed {
        ex_ctrl_t  ex;
        mem_ctrl_t mem;
        wb_ctrl_t  wb;
    } ctrl_t;

endpackage

// File: rtl/pipe_control_unit_decoder.sv
// ctrl_decoder: purely combinational opcode -> control bundle decode, zero latency.
// No backpressure; flags FENCE/ECALL/EBREAK/illegal for the sequencing logic upstream.
module ctrl_decoder
    import pipe_control_unit_pkg::*;
#(
    parameter bit EN_M = 1'b0
) (
    input  logic [31:0] instr_i,
    output ctrl_t       ctrl_o,
    output logic        illegal_o,
    output logic        fence_o,
    output logic        ecall_o,
    output logic        ebreak_o
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       unused_fields;

    assign opcode        = instr_i[OPC_MSB:OPC_LSB];
    assign funct3        = instr_i[F3_MSB:F3_LSB];
    assign funct7        = instr_i[F7_MSB:F7_LSB];
    assign unused_fields = ^{instr_i[24:21], instr_i[19:15], instr_i[11:7]};

    always_comb begin
        ctrl_o    = '0;
        illegal_o = 1'b0;
        fence_o   = 1'b0;
        ecall_o   = 1'b0;
        ebreak_o  = 1'b0;
        case (opcode)
            OPC_ARITH_R: begin
                if (funct7 == F7_BASE || funct7 == F7_ALT || (EN_M && funct7 == F7_MULDIV)) begin
                    ctrl_o.ex.alu_op    = ALU_FUNCT;
                    ctrl_o.wb.reg_write = 1'b1;
                end else begin
                    illegal_o = 1'b1;
                end
            end
            OPC_ARITH_I: begin
                ctrl_o.ex.alu_op    = ALU_FUNCT;
                ctrl_o.ex.alu_src   = 1'b1;
                ctrl_o.wb.reg_write = 1'b1;
            end
            OPC_LOAD: begin
                ctrl_o.ex.alu_op     = ALU_ADD;
                ctrl_o.ex.alu_src    = 1'b1;
                ctrl_o.mem.mem_read  = 1'b1;
                ctrl_o.wb.reg_write  = 1'b1;
                ctrl_o.wb.mem_to_reg = 1'b1;
            end
            OPC_STORE: begin
                ctrl_o.ex.alu_op     = ALU_ADD;
                ctrl_o.ex.alu_src    = 1'b1;
                ctrl_o.mem.mem_write = 1'b1;
                case (funct3)
                    F3_SB:   ctrl_o.mem.save_method = 2'b00;
                    F3_SH:   ctrl_o.mem.save_method = 2'b01;
                    F3_SW:   ctrl_o.mem.save_method = 2'b10;
                    default: begin
                        ctrl_o    = '0;
                        illegal_o = 1'b1;
                    end
                endcase
            end
            OPC_BRANCH: begin
                ctrl_o.ex.alu_op = ALU_BRANCH;
                ctrl_o.ex.branch = 1'b1;
            end
            OPC_LUI: begin
                ctrl_o.ex.alu_op    = ALU_LUI;
                ctrl_o.ex.alu_src   = 1'b1;
                ctrl_o.wb.reg_write = 1'b1;
            end
            OPC_AUIPC: begin
                ctrl_o.ex.alu_op    = ALU_ADD;
                ctrl_o.ex.alu_src   = 1'b1;
                ctrl_o.ex.auipc_sel = 1'b1;
                ctrl_o.wb.reg_write = 1'b1;
            end
            // Link writeback (PC+4) is selected through rf_sel for both jumps.
            OPC_JAL: begin
                ctrl_o.ex.branch    = 1'b1;
                ctrl_o.ex.jump      = 1'b1;
                ctrl_o.ex.rf_sel    = 1'b1;
                ctrl_o.wb.reg_write = 1'b1;
            end
            OPC_JALR: begin
                ctrl_o.ex.branch    = 1'b1;
                ctrl_o.ex.jump      = 1'b1;
                ctrl_o.ex.jalr      = 1'b1;
                ctrl_o.ex.alu_src   = 1'b1;
                ctrl_o.ex.rf_sel    = 1'b1;
                ctrl_o.wb.reg_write = 1'b1;
            end
            OPC_FENCE: fence_o = 1'b1;
            OPC_SYSTEM: begin
                ebreak_o = instr_i[SYS_IMM_BIT];
                ecall_o  = ~instr_i[SYS_IMM_BIT];
            end
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/pipe_control_unit.sv
// Decodes the ID instruction and carries controls through ID/EX, EX/MEM, WB; ex +1, mem +2, wb +3 cycles.
// stall_i freezes every stage and the PC; flush_i bubbles ID/EX; FENCE drains, EBREAK halts until resume_i.
module pipe_control_unit
    import pipe_control_unit_pkg::*;
#(
    parameter int N           = 32,
    parameter bit EN_M        = 1'b0,
    parameter int FENCE_DRAIN = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] instr_i,
    input  logic         instr_valid_i,
    input  logic         stall_i,
    input  logic         flush_i,
    input  logic         resume_i,
    output logic [1:0]   ex_alu_op,
    output logic         ex_alu_src,
    output logic         ex_branch,
    output logic         ex_jump,
    output logic         ex_jalr,
    output logic         ex_auipc_sel,
    output logic         ex_rf_sel,
    output logic         mem_read,
    output logic         mem_write,
    output logic [1:0]   mem_save_method,
    output logic         wb_reg_write,
    output logic         wb_mem_to_reg,
    output logic         load_pc,
    output logic         halted_o,
    output logic         illegal_o
);

    localparam logic [1:0] ST_RUN_ENC   = 2'd0;
    localparam logic [1:0] ST_DRAIN_ENC = 2'd1;
    localparam logic [1:0] ST_HALT_ENC  = 2'd2;
    localparam logic [DRAIN_CNT_W-1:0] DRAIN_INIT = DRAIN_CNT_W'(FENCE_DRAIN);

    typedef enum logic [1:0] {
        ST_RUN   = ST_RUN_ENC,
        ST_DRAIN = ST_DRAIN_ENC,
        ST_HALT  = ST_HALT_ENC
    } state_t;

    ctrl_t dec_ctrl;
    logic  dec_illegal, dec_fence, dec_ecall, dec_ebreak;

    ctrl_decoder #(.EN_M(EN_M)) u_decoder (
        .instr_i   (instr_i[31:0]),
        .ctrl_o    (dec_ctrl),
        .illegal_o (dec_illegal),
        .fence_o   (dec_fence),
        .ecall_o   (dec_ecall),
        .ebreak_o  (dec_ebreak)
    );

    state_t                 state_q, state_d;
    logic [DRAIN_CNT_W-1:0] cnt_q, cnt_d;
    ctrl_t                  idex_q, idex_d;
    logic                   idex_vld_q, idex_vld_d;
    mem_ctrl_t              exmem_mem_q, exmem_mem_d;
    wb_ctrl_t               exmem_wb_q, exmem_wb_d;
    logic                   exmem_vld_q, exmem_vld_d;
    wb_ctrl_t               wb_q, wb_d;
    logic                   wb_vld_q, wb_vld_d;
    logic                   illegal_q, illegal_d;
    logic                   stall_seen_q, stall_seen_d;
    logic                   issue;
    logic                   id_live;

    assign id_live = instr_valid_i && !flush_i && (state_q == ST_RUN);
    assign issue   = id_live && !dec_illegal && !dec_fence && !dec_ecall && !dec_ebreak;

    always_comb begin
        idex_vld_d  = idex_vld_q;
        idex_d      = idex_q;
        exmem_vld_d = exmem_vld_q;
        exmem_mem_d = exmem_mem_q;
        exmem_wb_d  = exmem_wb_q;
        wb_vld_d    = wb_vld_q;
        wb_d        = wb_q;
        if (flush_i) begin
            idex_vld_d = 1'b0;
            idex_d     = '0;
        end else if (!stall_i) begin
            idex_vld_d = issue;
            idex_d     = issue ? dec_ctrl : '0;
        end
        if (!stall_i) begin
            exmem_vld_d = idex_vld_q;
            exmem_mem_d = idex_vld_q ? idex_q.mem : '0;
            exmem_wb_d  = idex_vld_q ? idex_q.wb : '0;
            wb_vld_d    = exmem_vld_q;
            wb_d        = exmem_vld_q ? exmem_wb_q : '0;
        end
    end

    // An instruction held in ID across a stall reports illegal only on its first cycle.
    assign stall_seen_d = stall_i;
    assign illegal_d    = id_live && dec_illegal && !stall_seen_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RUN: begin
                if (id_live && !stall_i) begin
                    if (dec_fence) begin
                        state_d = ST_DRAIN;
                        cnt_d   = DRAIN_INIT;
                    end else if (dec_ebreak) begin
                        state_d = ST_HALT;
                    end
                end
            end
            ST_DRAIN: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q <= 1) begin
                    state_d = ST_RUN;
                end
            end
            ST_HALT: begin
                if (resume_i) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_RUN;
            cnt_q        <= '0;
            idex_q       <= '0;
            idex_vld_q   <= 1'b0;
            exmem_mem_q  <= '0;
            exmem_wb_q   <= '0;
            exmem_vld_q  <= 1'b0;
            wb_q         <= '0;
            wb_vld_q     <= 1'b0;
            illegal_q    <= 1'b0;
            stall_seen_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idex_q       <= idex_d;
            idex_vld_q   <= idex_vld_d;
            exmem_mem_q  <= exmem_mem_d;
            exmem_wb_q   <= exmem_wb_d;
            exmem_vld_q  <= exmem_vld_d;
            wb_q         <= wb_d;
            wb_vld_q     <= wb_vld_d;
            illegal_q    <= illegal_d;
            stall_seen_q <= stall_seen_d;
        end
    end

    ex_ctrl_t  ex_out;
    mem_ctrl_t mem_out;
    wb_ctrl_t  wb_out;

    assign ex_out  = idex_vld_q  ? idex_q.ex   : '0;
    assign mem_out = exmem_vld_q ? exmem_mem_q : '0;
    assign wb_out  = wb_vld_q    ? wb_q        : '0;

    assign ex_alu_op       = ex_out.alu_op;
    assign ex_alu_src      = ex_out.alu_src;
    assign ex_branch       = ex_out.branch;
    assign ex_jump         = ex_out.jump;
    assign ex_jalr         = ex_out.jalr;
    assign ex_auipc_sel    = ex_out.auipc_sel;
    assign ex_rf_sel       = ex_out.rf_sel;
    assign mem_read        = mem_out.mem_read;
    assign mem_write       = mem_out.mem_write;
    assign mem_save_method = mem_out.save_method;
    assign wb_reg_write    = wb_out.reg_write;
    assign wb_mem_to_reg   = wb_out.mem_to_reg;

    assign load_pc   = (state_q == ST_RUN) && !stall_i;
    assign halted_o  = (state_q == ST_HALT);
    assign illegal_o = illegal_q;

endmodule

// File: tb/tb_pipe_control_unit.sv
// Directed-vector bench for pipe_control_unit with hand-computed expectations.
module tb_pipe_control_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr_i;
    logic        instr_valid_i, stall_i, flush_i, resume_i;
    logic [1:0]  ex_alu_op, mem_save_method;
    logic        ex_alu_src, ex_branch, ex_jump, ex_jalr, ex_auipc_sel, ex_rf_sel;
    logic        mem_read, mem_write, wb_reg_write, wb_mem_to_reg;
    logic        load_pc, halted_o, illegal_o;

    int total = 0;
    int bad   = 0;
    int pulses;

    localparam logic [31:0] I_ADD    = 32'h003100B3;
    localparam logic [31:0] I_SW     = 32'h00212023;
    localparam logic [31:0] I_SBAD   = 32'h00213023;
    localparam logic [31:0] I_LW     = 32'h00012083;
    localparam logic [31:0] I_JAL    = 32'h0000006F;
    localparam logic [31:0] I_FENCE  = 32'h0000000F;
    localparam logic [31:0] I_EBREAK = 32'h00100073;
    localparam logic [31:0] I_ECALL  = 32'h00000073;
    localparam logic [31:0] I_BAD    = 32'h0000007F;
    localparam logic [31:0] I_MUL    = 32'h02208033;

    pipe_control_unit dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .instr_i         (instr_i),
        .instr_valid_i   (instr_valid_i),
        .stall_i         (stall_i),
        .flush_i         (flush_i),
        .resume_i        (resume_i),
        .ex_alu_op       (ex_alu_op),
        .ex_alu_src      (ex_alu_src),
        .ex_branch       (ex_branch),
        .ex_jump         (ex_jump),
        .ex_jalr         (ex_jalr),
        .ex_auipc_sel    (ex_auipc_sel),
        .ex_rf_sel       (ex_rf_sel),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_save_method (mem_save_method),
        .wb_reg_write    (wb_reg_write),
        .wb_mem_to_reg   (wb_mem_to_reg),
        .load_pc         (load_pc),
        .halted_o        (halted_o),
        .illegal_o       (illegal_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [31:0] ins);
        instr_i       = ins;
        instr_valid_i = 1'b1;
    endtask

    task automatic idle();
        instr_i       = 32'h0;
        instr_valid_i = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; stall_i = 1'b0; flush_i = 1'b0; resume_i = 1'b0;
        idle();
        tick(); tick();
        chk("rst_halted", halted_o, 0);
        chk("rst_illegal", illegal_o, 0);
        chk("rst_ex_alu_op", ex_alu_op, 0);
        chk("rst_mem_read", mem_read, 0);
        chk("rst_wb_reg_write", wb_reg_write, 0);
        rst_n = 1'b1;
        #1;
        chk("rst_load_pc", load_pc, 1);

        // ADD: ex at +1, wb at +3
        issue(I_ADD);
        tick(); idle();
        chk("add_ex_alu_op", ex_alu_op, 2'b10);
        chk("add_ex_alu_src", ex_alu_src, 0);
        tick();
        chk("add_mem_read", mem_read, 0);
        tick();
        chk("add_wb_reg_write", wb_reg_write, 1);
        chk("add_wb_mem_to_reg", wb_mem_to_reg, 0);
        tick();
        chk("add_wb_drained", wb_reg_write, 0);

        // SW: mem_write/save_method at +2, no writeback
        issue(I_SW);
        tick(); idle();
        chk("sw_ex_alu_src", ex_alu_src, 1);
        chk("sw_ex_alu_op", ex_alu_op, 2'b00);
        tick();
        chk("sw_mem_write", mem_write, 1);
        chk("sw_save_method", mem_save_method, 2'b10);
        tick();
        chk("sw_wb_reg_write", wb_reg_write, 0);

        // LW held by a 3-cycle stall: mem_read appears at +5 instead of +2
        issue(I_LW);
        tick(); idle();
        stall_i = 1'b1;
        #1;
        chk("lw_stall_load_pc", load_pc, 0);
        tick(); tick(); tick();
        chk("lw_stall_ex_held", ex_alu_src, 1);
        chk("lw_stall_mem_read", mem_read, 0);
        stall_i = 1'b0;
        tick();
        chk("lw_mem_read_late", mem_read, 1);
        tick();
        chk("lw_wb_mem_to_reg", wb_mem_to_reg, 1);
        tick(); tick();

        // JAL unflushed, then JAL flushed in ID
        issue(I_JAL);
        tick(); idle();
        chk("jal_ex_jump", ex_jump, 1);
        chk("jal_ex_rf_sel", ex_rf_sel, 1);
        issue(I_JAL); flush_i = 1'b1;
        tick(); idle(); flush_i = 1'b0;
        chk("jal_flush_ex_jump", ex_jump, 0);
        chk("jal_flush_ex_branch", ex_branch, 0);

        // FENCE: PC frozen for exactly FENCE_DRAIN=2 cycles
        issue(I_FENCE);
        #1;
        chk("fence_id_load_pc", load_pc, 1);
        tick(); idle();
        chk("fence_d1_load_pc", load_pc, 0);
        tick();
        chk("fence_d2_load_pc", load_pc, 0);
        tick();
        chk("fence_done_load_pc", load_pc, 1);

        // ECALL does not halt
        issue(I_ECALL);
        tick(); idle();
        chk("ecall_halted", halted_o, 0);
        chk("ecall_load_pc", load_pc, 1);

        // EBREAK flushed in ID: no state change
        issue(I_EBREAK); flush_i = 1'b1;
        tick(); idle(); flush_i = 1'b0;
        chk("ebreak_flush_halted", halted_o, 0);

        // EBREAK halts until resume; instructions during HALT are bubbles
        issue(I_EBREAK);
        tick();
        chk("ebreak_halted", halted_o, 1);
        chk("ebreak_load_pc", load_pc, 0);
        issue(I_ADD);
        tick(); idle();
        chk("halt_still", halted_o, 1);
        chk("halt_bubble_alu_op", ex_alu_op, 0);
        resume_i = 1'b1;
        tick(); resume_i = 1'b0;
        chk("resume_halted", halted_o, 0);
        chk("resume_load_pc", load_pc, 1);

        // Illegal opcode pulses once
        issue(I_BAD);
        tick(); idle();
        chk("bad_illegal_pulse", illegal_o, 1);
        tick();
        chk("bad_illegal_clear", illegal_o, 0);

        // Illegal held in ID through a 3-cycle stall: exactly one pulse
        pulses = 0;
        issue(I_BAD); stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (illegal_o === 1'b1) pulses++;
        end
        stall_i = 1'b0;
        tick(); idle();
        if (illegal_o === 1'b1) pulses++;
        tick();
        if (illegal_o === 1'b1) pulses++;
        chk("bad_stall_pulses", pulses, 1);

        // Store with undefined funct3, and MUL without EN_M, are illegal
        issue(I_SBAD);
        tick(); idle();
        chk("sbad_illegal", illegal_o, 1);
        chk("sbad_bubble_alu_src", ex_alu_src, 0);
        issue(I_MUL);
        tick(); idle();
        chk("mul_illegal", illegal_o, 1);
        chk("mul_bubble_alu_op", ex_alu_op, 0);

        // Reset during HALT
        issue(I_EBREAK);
        tick(); idle();
        chk("halt_before_rst", halted_o, 1);
        rst_n = 1'b0;
        tick();
        chk("rst_in_halt_halted", halted_o, 0);
        rst_n = 1'b1;

        // Reset during DRAIN abandons the drain
        issue(I_FENCE);
        tick(); idle();
        chk("drain_before_rst", load_pc, 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        chk("rst_in_drain_load_pc", load_pc, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
